// File: rtl/cdc_push_arbiter.sv
// cdc_push_arbiter: round-robin arbiter sharing the write port of a single-entry CDC FIFO.
// Grants one requester, issues a single-cycle push, then follows the FIFO full flag up and back down.
module cdc_push_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 49,
    parameter int FULL_TO = 15,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_fifo_push,
    output logic [ID_W+DATA_W-1:0]    o_fifo_wdata,
    input  logic                      i_fifo_full,
    output logic                      o_busy,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_err_timeout,
    output logic [CNT_W-1:0]          o_push_cnt
);
    localparam int              WD_W    = $clog2(FULL_TO + 1);
    localparam logic [ID_W:0]   NR      = (ID_W+1)'(NUM_REQ);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(FULL_TO - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, PUSH, WAIT_FULL, WAIT_DRAIN} state_t;

    state_t               r_state, w_next;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [WD_W-1:0]      r_wd;
    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_any;
    logic [ID_W-1:0]      w_off, w_gnt;
    logic [ID_W:0]        w_sum;
    logic [DATA_W-1:0]    w_data;
    logic                 w_grant, w_timeout;

    // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
    assign w_rot = {i_req_valid, i_req_valid} >> r_rr_ptr;

    always_comb begin
        w_any = 1'b0;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_any = 1'b1;
                w_off = ID_W'(k);
            end
        end
    end

    assign w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_gnt = (w_sum >= NR) ? ID_W'(w_sum - NR) : w_sum[ID_W-1:0];

    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt == ID_W'(k)) w_data = i_req_data[k*DATA_W +: DATA_W];
        end
    end

    assign w_grant   = (r_state == IDLE) && w_any && !i_fifo_full;
    assign w_timeout = (r_state == WAIT_FULL) && !i_fifo_full && (r_wd == WD_LAST);

    always_comb begin
        w_next      = r_state;
        o_req_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next      = PUSH;
                    o_req_ready = NUM_REQ'(1) << w_gnt;
                end
            end
            PUSH:       w_next = WAIT_FULL;
            WAIT_FULL:  w_next = i_fifo_full ? WAIT_DRAIN : (w_timeout ? IDLE : WAIT_FULL);
            WAIT_DRAIN: w_next = i_fifo_full ? WAIT_DRAIN : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // Push is a pure state decode; WAIT_FULL guarantees the low cycle the FIFO edge detector needs.
    assign o_fifo_push = (r_state == PUSH);
    assign o_busy      = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rr_ptr      <= '0;
            r_wd          <= '0;
            o_fifo_wdata  <= '0;
            o_grant_id    <= '0;
            o_err_timeout <= 1'b0;
            o_push_cnt    <= '0;
        end else begin
            if (w_grant) begin
                o_fifo_wdata <= {w_gnt, w_data};
                o_grant_id   <= w_gnt;
                r_rr_ptr     <= (w_gnt == ID_LAST) ? '0 : w_gnt + 1'b1;
            end
            if (r_state == PUSH) begin
                o_push_cnt <= o_push_cnt + 1'b1;
                r_wd       <= '0;
            end
            if (r_state == WAIT_FULL && !i_fifo_full) r_wd <= r_wd + 1'b1;
            if (w_timeout) o_err_timeout <= 1'b1;
        end
    end
endmodule

// File: doc/cdc_push_arbiter.md
Name: cdc_push_arbiter

Overview:
- Round-robin arbiter that shares the write side of the single-entry CDC FIFO (async_fifo, ADDRSIZE=1) among NUM_REQ requesters in the write clock domain.
- Accepts one request, tags its payload with the requester ID, and issues a single rising-edge push, since the FIFO edge-detects wpush.
- Tracks the FIFO's registered full flag through its full rise/fall cycle before granting again.
- Sits between the local masters and the FIFO wpush/wdata/wfull pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester tag width; must satisfy 2**ID_W >= NUM_REQ.
- DATA_W, 49, payload width per requester; fifo_wdata width is ID_W+DATA_W (51 at default).
- FULL_TO, 15, watchdog limit in cycles for fifo_full to rise after a push.
- CNT_W, 16, push counter width.

Ports:
- clk  in  1  write-domain clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_data  in  NUM_REQ*DATA_W  payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- fifo_push  out  1  to FIFO wpush.
- fifo_wdata  out  ID_W+DATA_W  to FIFO wdata, formatted {id, data}.
- fifo_full  in  1  from FIFO wfull.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  ID_W  ID of the last granted requester.
- err_timeout  out  1  sticky watchdog error.
- push_cnt  out  CNT_W  count of pushes issued, wraps.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; rr_ptr=0.
  - req_ready=0, fifo_push=0, fifo_wdata=0, grant_id=0.
  - err_timeout=0, push_cnt=0, busy=0, watchdog counter=0.
  - Any in-flight transfer is abandoned. A requester already acked is not re-acked.
- States: IDLE, PUSH, WAIT_FULL, WAIT_DRAIN.
- IDLE, when any req_valid=1 and fifo_full=0:
  - Grant g is the first requester with req_valid set, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle; this is the only cycle req_ready is high.
  - At the clock edge: fifo_wdata <= {g, req_data[g]}, grant_id <= g, rr_ptr <= (g+1) mod NUM_REQ, go to PUSH.
- IDLE with fifo_full=1: no grant; all req_ready=0; stay in IDLE.
- PUSH:
  - fifo_push=1 for exactly one cycle; fifo_wdata is held stable.
  - push_cnt increments, wrapping at 2**CNT_W.
  - Clear the watchdog counter; go to WAIT_FULL.
- WAIT_FULL:
  - fifo_push=0, which provides the low cycle the FIFO edge detector needs before the next push.
  - Wait for fifo_full=1. The FIFO's registered full flag rises two cycles after the push cycle.
  - On fifo_full=1: go to WAIT_DRAIN.
  - Otherwise the watchdog counter increments. When it reaches FULL_TO: set err_timeout=1 and go to IDLE.
- WAIT_DRAIN: wait for fifo_full=0, i.e. the read domain popped and the pointer synchronised back, then go to IDLE.
- fifo_wdata holds its last value until the next grant; it never changes while fifo_push=1.
- Nominal latency: req_valid at cycle t -> req_ready at t -> fifo_push at t+1 -> fifo_full observed at t+3 -> WAIT_DRAIN from t+4.
  - The minimum request-to-request grant interval is therefore about 5 cycles plus the drain time.
- Requester rules:
  - A requester must hold req_valid and req_data stable until it sees req_ready.
  - Dropping req_valid before the grant is allowed and removes that requester from arbitration.
- Simultaneous requests: exactly one grant per IDLE pass; the others wait and are served in rotation order.
- err_timeout clears only on reset.

Test Plan:
- Single request: req_valid[2]=1, data=0x1_2345_6789_ABCD, FIFO drained 10 cycles after push -> req_ready[2] in cycle 0, fifo_push only in cycle 1, fifo_wdata={2'd2,data}, busy until fifo_full falls, push_cnt=1.
- Fairness: all four req_valid held high, FIFO drains immediately -> grant order 0,1,2,3,0; each req_ready one-hot and one cycle wide.
- Push spacing: back-to-back grants -> fifo_push is never high in two consecutive cycles, and the async_fifo model accepts every push (4 entries read out in order with the correct IDs).
- Full at idle: hold fifo_full=1 with req_valid[1]=1 -> no req_ready and no push; release fifo_full -> grant to 1 the next cycle.
- Watchdog: stub fifo_full stuck at 0 after a push -> err_timeout=1 after 15 cycles in WAIT_FULL, state returns to IDLE, and err_timeout stays high through later traffic.
- Reset mid-operation: assert rstn=0 while in WAIT_DRAIN -> all outputs go to reset values immediately with no clock; after release, rr_ptr=0 and the next grant goes to the lowest-index valid requester.
